// File: rtl/hall_dispatch_if.sv
// Hall-call dispatcher bus: button presses in, car status in, car assignments and call lamps out.
// Latency: none, wires only.
// Backpressure: hall_req valid/ready and assign valid/ready handshakes.
// Ports grouped: hall_req_* (button press), car_floor/car_idle (car status),
//   assign_* (assignment offer), pending_up/pending_dn (call lamps).
// master = button/car-controller side, slave = dispatcher.
interface hall_dispatch_if #(
    parameter int ELEVATOR_COUNT = 2,
    parameter int FLOOR_COUNT    = 7,
    parameter int FLOOR_W        = 3,
    parameter int CAR_W          = 1
) ();
    logic                              hall_req_valid;
    logic [FLOOR_W-1:0]                hall_req_floor;
    logic                              hall_req_up;
    logic                              hall_req_ready;
    logic [ELEVATOR_COUNT*FLOOR_W-1:0] car_floor;
    logic [ELEVATOR_COUNT-1:0]         car_idle;
    logic                              assign_valid;
    logic [CAR_W-1:0]                  assign_car;
    logic [FLOOR_W-1:0]                assign_floor;
    logic                              assign_up;
    logic                              assign_ready;
    logic [FLOOR_COUNT-1:0]            pending_up;
    logic [FLOOR_COUNT-1:0]            pending_dn;

    modport master (
        output hall_req_valid, hall_req_floor, hall_req_up, car_floor, car_idle, assign_ready,
        input  hall_req_ready, assign_valid, assign_car, assign_floor, assign_up,
               pending_up, pending_dn
    );

    modport slave (
        input  hall_req_valid, hall_req_floor, hall_req_up, car_floor, car_idle, assign_ready,
        output hall_req_ready, assign_valid, assign_car, assign_floor, assign_up,
               pending_up, pending_dn
    );
endinterface

// File: rtl/hall_dispatch.sv
// Hall-call dispatcher: latches up/down presses and scans them, offering each to an idle car.
// Latency: press to lamp 1 cycle; set entry under the scan pointer to assign_valid 1 cycle.
// Backpressure: presses always accepted out of reset; an offer is held until assign_ready.
// Ports: clk, reset (async active-high), bus (hall_dispatch_if.slave).
// Option: define HALL_DISPATCH_NEAREST_EN for nearest-idle-car choice (ties to lowest index);
//   the default build picks cars round-robin starting after the last assigned car.
module hall_dispatch #(
    parameter int ELEVATOR_COUNT = 2,
    parameter int FLOOR_COUNT    = 7,
    parameter int FLOOR_W        = 3,
    parameter int CAR_W          = 1
) (
    input  logic           clk,
    input  logic           reset,
    hall_dispatch_if.slave bus
);
    localparam int ENTRIES = 2 * FLOOR_COUNT;
    localparam int PTR_W   = $clog2(ENTRIES);

    typedef enum logic {SCAN, OFFER} state_t;

    state_t                 state;
    logic [PTR_W-1:0]       ptr;
    logic [PTR_W-1:0]       ptr_next;
    logic [FLOOR_COUNT-1:0] pend_up;
    logic [FLOOR_COUNT-1:0] pend_dn;
    logic [FLOOR_COUNT-1:0] set_up;
    logic [FLOOR_COUNT-1:0] set_dn;
    logic [FLOOR_COUNT-1:0] clr_up;
    logic [FLOOR_COUNT-1:0] clr_dn;
    logic [FLOOR_W-1:0]     scan_floor;
    logic                   scan_up;
    logic                   entry_set;
    logic                   press_ok;
    logic                   handshake;
    logic                   any_idle;
    logic [CAR_W-1:0]       pick_car;

    // Entry 2*f is floor f up, entry 2*f+1 is floor f down.
    assign scan_floor = FLOOR_W'(ptr >> 1);
    assign scan_up    = ~ptr[0];
    assign ptr_next   = (ptr == PTR_W'(ENTRIES - 1)) ? '0 : ptr + PTR_W'(1);
    assign any_idle   = |bus.car_idle;
    assign handshake  = (state == OFFER) && bus.assign_ready;

    assign bus.hall_req_ready = ~reset;
    assign bus.pending_up     = pend_up;
    assign bus.pending_dn     = pend_dn;

    // Range check done one bit wider so FLOOR_COUNT == 2**FLOOR_W does not wrap to 0.
    assign press_ok = bus.hall_req_valid && bus.hall_req_ready
                   && ({1'b0, bus.hall_req_floor} < (FLOOR_W + 1)'(FLOOR_COUNT))
                   && !( bus.hall_req_up && bus.hall_req_floor == FLOOR_W'(FLOOR_COUNT - 1))
                   && !(!bus.hall_req_up && bus.hall_req_floor == '0);

    // The pointer is held during OFFER, so the scanned entry is the one being cleared.
    always_comb begin
        set_up    = '0;
        set_dn    = '0;
        clr_up    = '0;
        clr_dn    = '0;
        entry_set = 1'b0;
        for (int i = 0; i < FLOOR_COUNT; i++) begin
            if (press_ok && bus.hall_req_floor == FLOOR_W'(i)) begin
                if (bus.hall_req_up) set_up[i] = 1'b1;
                else                 set_dn[i] = 1'b1;
            end
            if (scan_floor == FLOOR_W'(i)) begin
                entry_set = scan_up ? pend_up[i] : pend_dn[i];
                if (handshake) begin
                    if (scan_up) clr_up[i] = 1'b1;
                    else         clr_dn[i] = 1'b1;
                end
            end
        end
    end

`ifdef HALL_DISPATCH_NEAREST_EN
    logic [FLOOR_W:0] best_dist;
    logic [FLOOR_W:0] dist;
    logic [FLOOR_W:0] cf_ext;
    logic             found;

    // Strict '<' keeps the lowest index on a distance tie.
    always_comb begin
        pick_car  = '0;
        best_dist = '0;
        dist      = '0;
        cf_ext    = '0;
        found     = 1'b0;
        for (int i = 0; i < ELEVATOR_COUNT; i++) begin
            cf_ext = {1'b0, bus.car_floor[i*FLOOR_W +: FLOOR_W]};
            dist   = (cf_ext >= {1'b0, scan_floor}) ? cf_ext - {1'b0, scan_floor}
                                                    : {1'b0, scan_floor} - cf_ext;
            if (bus.car_idle[i] && (!found || dist < best_dist)) begin
                found     = 1'b1;
                best_dist = dist;
                pick_car  = CAR_W'(i);
            end
        end
    end
`else
    logic [CAR_W-1:0] last_car;
    logic [CAR_W-1:0] hi_car;
    logic [CAR_W-1:0] lo_car;
    logic             found_hi;
    logic             found_lo;

    // First idle car above last_car; if none, wrap to the lowest idle car.
    always_comb begin
        hi_car   = '0;
        lo_car   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = 0; i < ELEVATOR_COUNT; i++) begin
            if (bus.car_idle[i]) begin
                if (!found_lo) begin
                    found_lo = 1'b1;
                    lo_car   = CAR_W'(i);
                end
                if (!found_hi && CAR_W'(i) > last_car) begin
                    found_hi = 1'b1;
                    hi_car   = CAR_W'(i);
                end
            end
        end
        pick_car = found_hi ? hi_car : lo_car;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          last_car <= CAR_W'(ELEVATOR_COUNT - 1);
        else if (handshake) last_car <= bus.assign_car;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= SCAN;
            ptr              <= '0;
            pend_up          <= '0;
            pend_dn          <= '0;
            bus.assign_valid <= 1'b0;
            bus.assign_car   <= '0;
            bus.assign_floor <= '0;
            bus.assign_up    <= 1'b0;
        end else begin
            // Clear beats a same-cycle press on the entry being served.
            pend_up <= (pend_up | set_up) & ~clr_up;
            pend_dn <= (pend_dn | set_dn) & ~clr_dn;
            case (state)
                SCAN: begin
                    if (!entry_set) begin
                        ptr <= ptr_next;
                    end else if (any_idle) begin
                        bus.assign_car   <= pick_car;
                        bus.assign_floor <= scan_floor;
                        bus.assign_up    <= scan_up;
                        bus.assign_valid <= 1'b1;
                        state            <= OFFER;
                    end
                end
                OFFER: begin
                    if (bus.assign_ready) begin
                        bus.assign_valid <= 1'b0;
                        ptr              <= ptr_next;
                        state            <= SCAN;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_hall_dispatch.sv
// Testbench for hall_dispatch: directed scenarios plus a randomized run against a call-set model.
// Latency: n/a.
// Backpressure: assign_ready driven directly, randomly in the random run.
module tb_hall_dispatch;
    localparam int EC = 2;
    localparam int FC = 7;
    localparam int FW = 3;
    localparam int CW = 1;

    logic clk = 1'b0;
    logic reset;

    hall_dispatch_if #(.ELEVATOR_COUNT(EC), .FLOOR_COUNT(FC), .FLOOR_W(FW), .CAR_W(CW)) bus ();

    hall_dispatch #(.ELEVATOR_COUNT(EC), .FLOOR_COUNT(FC), .FLOOR_W(FW), .CAR_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: set of outstanding calls and the last car that took a call.
    bit m_up [FC];
    bit m_dn [FC];
    int m_last;

    function automatic logic [FC-1:0] model_up();
        logic [FC-1:0] v;
        for (int i = 0; i < FC; i++) v[i] = m_up[i];
        return v;
    endfunction

    function automatic logic [FC-1:0] model_dn();
        logic [FC-1:0] v;
        for (int i = 0; i < FC; i++) v[i] = m_dn[i];
        return v;
    endfunction

    function automatic bit press_legal(int f, bit up);
        return (f < FC) && !(up && f == FC - 1) && !(!up && f == 0);
    endfunction

    function automatic int model_choice(logic [EC-1:0] idle, logic [EC*FW-1:0] fl, int call_f);
        int best = -1;
`ifdef HALL_DISPATCH_NEAREST_EN
        int bd = 0;
        for (int i = 0; i < EC; i++) begin
            int d = int'(fl[i*FW +: FW]) - call_f;
            if (d < 0) d = -d;
            if (idle[i] && (best < 0 || d < bd)) begin
                best = i;
                bd   = d;
            end
        end
`else
        for (int k = 1; k <= EC; k++) begin
            int c = (m_last + k) % EC;
            if (best < 0 && idle[c]) best = c;
        end
`endif
        return best;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < FC; i++) begin
            m_up[i] = 1'b0;
            m_dn[i] = 1'b0;
        end
        m_last = EC - 1;
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        bus.hall_req_valid = 1'b0;
        bus.hall_req_floor = '0;
        bus.hall_req_up    = 1'b0;
        bus.assign_ready   = 1'b0;
        bus.car_idle       = '0;
        bus.car_floor      = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    // One-cycle press, starting and ending at a falling edge.
    task automatic press(int f, bit up);
        bus.hall_req_valid = 1'b1;
        bus.hall_req_floor = FW'(f);
        bus.hall_req_up    = up;
        @(negedge clk);
        bus.hall_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset              = 1'b1;
        bus.hall_req_valid = 1'b1;
        bus.hall_req_floor = 3'd2;
        bus.hall_req_up    = 1'b1;
        bus.assign_ready   = 1'b0;
        bus.car_idle       = '1;
        bus.car_floor      = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.hall_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 0", bus.hall_req_ready);
        end
        checks++;
        if ({bus.pending_up, bus.pending_dn} !== '0) begin
            failures++;
            $display("FAIL reset_lamps: got %h/%h expected 0/0", bus.pending_up, bus.pending_dn);
        end
        checks++;
        if ({bus.assign_valid, bus.assign_car, bus.assign_floor, bus.assign_up} !== '0) begin
            failures++;
            $display("FAIL reset_assign: got v=%b car=%0d fl=%0d up=%b expected all 0",
                     bus.assign_valid, bus.assign_car, bus.assign_floor, bus.assign_up);
        end
        bus.hall_req_valid = 1'b0;
        reset = 1'b0;
        model_clear();
        #1;
        checks++;
        if (bus.hall_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got %b expected 1", bus.hall_req_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        int exp_car;
`ifdef HALL_DISPATCH_NEAREST_EN
        exp_car = 1;
`else
        exp_car = 0;
`endif
        do_reset();
        bus.car_floor = {3'd5, 3'd0};
        bus.car_idle  = 2'b11;
        press(3, 1'b1);
        checks++;
        if (bus.pending_up !== 7'b0001000) begin
            failures++;
            $display("FAIL basic_lamp: got %b expected 0001000", bus.pending_up);
        end
        for (int t = 0; t < 2*FC + 2 && !bus.assign_valid; t++) @(negedge clk);
        checks++;
        if (bus.assign_valid !== 1'b1 || int'(bus.assign_car) !== exp_car
            || bus.assign_floor !== 3'd3 || bus.assign_up !== 1'b1) begin
            failures++;
            $display("FAIL basic_offer: got v=%b car=%0d fl=%0d up=%b expected v=1 car=%0d fl=3 up=1",
                     bus.assign_valid, bus.assign_car, bus.assign_floor, bus.assign_up, exp_car);
        end
        bus.assign_ready = 1'b1;
        @(negedge clk);
        bus.assign_ready = 1'b0;
        checks++;
        if (bus.pending_up !== '0 || bus.assign_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_clear: got lamps=%b v=%b expected 0 0", bus.pending_up, bus.assign_valid);
        end
    endtask

    task automatic test_ignored();
        bit seen = 1'b0;
        do_reset();
        bus.car_idle = 2'b11;
        press(0, 1'b0);
        press(6, 1'b1);
        press(7, 1'b1);
        press(7, 1'b0);
        for (int t = 0; t < 2*FC + 2; t++) begin
            if (bus.assign_valid || bus.pending_up != 0 || bus.pending_dn != 0) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL ignored_presses: got activity=%b expected 0", seen);
        end
    endtask

    task automatic test_no_idle();
        bit seen = 1'b0;
        do_reset();
        bus.car_idle  = 2'b00;
        bus.car_floor = {3'd6, 3'd6};
        press(2, 1'b0);
        for (int t = 0; t < 20; t++) begin
            if (bus.assign_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0 || bus.pending_dn !== 7'b0000100) begin
            failures++;
            $display("FAIL no_idle_hold: got offered=%b lamps=%b expected 0 0000100", seen, bus.pending_dn);
        end
        bus.car_idle = 2'b01;
        for (int t = 0; t < 2 && !bus.assign_valid; t++) @(negedge clk);
        checks++;
        if (bus.assign_valid !== 1'b1 || bus.assign_car !== 1'b0
            || bus.assign_floor !== 3'd2 || bus.assign_up !== 1'b0) begin
            failures++;
            $display("FAIL idle_release: got v=%b car=%0d fl=%0d up=%b expected v=1 car=0 fl=2 up=0",
                     bus.assign_valid, bus.assign_car, bus.assign_floor, bus.assign_up);
        end
        bus.assign_ready = 1'b1;
        @(negedge clk);
        bus.assign_ready = 1'b0;
    endtask

    task automatic test_scan_order();
        int exp_car [3];
        int exp_fl  [3] = '{1, 2, 4};
        bit exp_up  [3] = '{1'b1, 1'b1, 1'b0};
`ifdef HALL_DISPATCH_NEAREST_EN
        exp_car = '{0, 0, 0};
`else
        exp_car = '{0, 1, 0};
`endif
        do_reset();
        bus.car_idle  = 2'b00;
        bus.car_floor = '0;
        press(1, 1'b1);
        press(2, 1'b1);
        press(4, 1'b0);
        checks++;
        if (bus.pending_up !== 7'b0000110 || bus.pending_dn !== 7'b0010000) begin
            failures++;
            $display("FAIL order_lamps: got %b/%b expected 0000110/0010000", bus.pending_up, bus.pending_dn);
        end
        bus.car_idle = 2'b11;
        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 2*FC + 2 && !bus.assign_valid; t++) @(negedge clk);
            checks++;
            if (bus.assign_valid !== 1'b1 || int'(bus.assign_car) !== exp_car[k]
                || int'(bus.assign_floor) !== exp_fl[k] || bus.assign_up !== exp_up[k]) begin
                failures++;
                $display("FAIL order_offer%0d: got v=%b car=%0d fl=%0d up=%b expected v=1 car=%0d fl=%0d up=%b",
                         k, bus.assign_valid, bus.assign_car, bus.assign_floor, bus.assign_up,
                         exp_car[k], exp_fl[k], exp_up[k]);
            end
            bus.assign_ready = 1'b1;
            @(negedge clk);
            bus.assign_ready = 1'b0;
            checks++;
            if (bus.assign_valid !== 1'b0) begin
                failures++;
                $display("FAIL order_gap%0d: got v=%b expected 0", k, bus.assign_valid);
            end
        end
    endtask

    task automatic test_clear_wins();
        bit seen = 1'b0;
        do_reset();
        bus.car_idle  = 2'b11;
        bus.car_floor = '0;
        press(4, 1'b1);
        for (int t = 0; t < 2*FC + 2 && !bus.assign_valid; t++) @(negedge clk);
        checks++;
        if (bus.assign_valid !== 1'b1 || bus.assign_floor !== 3'd4 || bus.assign_up !== 1'b1) begin
            failures++;
            $display("FAIL clear_offer: got v=%b fl=%0d up=%b expected 1 4 1",
                     bus.assign_valid, bus.assign_floor, bus.assign_up);
        end
        bus.assign_ready   = 1'b1;
        bus.hall_req_valid = 1'b1;
        bus.hall_req_floor = 3'd4;
        bus.hall_req_up    = 1'b1;
        @(negedge clk);
        bus.assign_ready   = 1'b0;
        bus.hall_req_valid = 1'b0;
        checks++;
        if (bus.pending_up !== '0) begin
            failures++;
            $display("FAIL clear_wins_lamp: got %b expected 0", bus.pending_up);
        end
        for (int t = 0; t < 2*FC + 2; t++) begin
            if (bus.assign_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL clear_wins_reoffer: got %b expected 0", seen);
        end
    endtask

    task automatic test_reset_mid_offer();
        do_reset();
        bus.car_idle  = 2'b00;
        bus.car_floor = '0;
        press(5, 1'b0);
        press(3, 1'b1);
        bus.car_idle = 2'b11;
        for (int t = 0; t < 2*FC + 2 && !bus.assign_valid; t++) @(negedge clk);
        checks++;
        if (bus.assign_valid !== 1'b1 || bus.assign_floor !== 3'd3) begin
            failures++;
            $display("FAIL mid_offer_setup: got v=%b fl=%0d expected 1 3", bus.assign_valid, bus.assign_floor);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.assign_valid !== 1'b0 || bus.pending_up !== '0 || bus.pending_dn !== '0
            || bus.hall_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got v=%b up=%b dn=%b rdy=%b expected 0 0 0 0",
                     bus.assign_valid, bus.pending_up, bus.pending_dn, bus.hall_req_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        press(1, 1'b1);
        for (int t = 0; t < 3 && !bus.assign_valid; t++) @(negedge clk);
        checks++;
        if (bus.assign_valid !== 1'b1 || bus.assign_floor !== 3'd1 || bus.assign_up !== 1'b1) begin
            failures++;
            $display("FAIL scan_restart: got v=%b fl=%0d up=%b expected 1 1 1",
                     bus.assign_valid, bus.assign_floor, bus.assign_up);
        end
        bus.assign_ready = 1'b1;
        @(negedge clk);
        bus.assign_ready = 1'b0;
    endtask

    task automatic test_random();
        bit                 in_offer = 1'b0;
        bit                 last_hs  = 1'b0;
        logic [EC-1:0]      prev_idle = '0;
        logic [EC*FW-1:0]   prev_fl   = '0;
        logic [CW-1:0]      o_car     = '0;
        logic [FW-1:0]      o_fl      = '0;
        logic               o_up      = 1'b0;
        int                 offers    = 0;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit v;
            bit rdy;
            bit hs;
            bit pv;
            bit pup;
            int pf;
            v = bus.assign_valid;
            checks++;
            if (bus.pending_up !== model_up() || bus.pending_dn !== model_dn()) begin
                failures++;
                $display("FAIL rand_lamps@%0d: got %b/%b expected %b/%b", cyc,
                         bus.pending_up, bus.pending_dn, model_up(), model_dn());
            end
            if (last_hs) begin
                checks++;
                if (v !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_gap@%0d: got v=%b expected 0", cyc, v);
                end
            end else if (in_offer) begin
                checks++;
                if (v !== 1'b1 || bus.assign_car !== o_car || bus.assign_floor !== o_fl
                    || bus.assign_up !== o_up) begin
                    failures++;
                    $display("FAIL rand_hold@%0d: got v=%b car=%0d fl=%0d up=%b expected 1 %0d %0d %b",
                             cyc, v, bus.assign_car, bus.assign_floor, bus.assign_up, o_car, o_fl, o_up);
                end
            end else if (v) begin
                int f = int'(bus.assign_floor);
                int ec = model_choice(prev_idle, prev_fl, f);
                bit pend = (f < FC) ? (bus.assign_up ? m_up[f] : m_dn[f]) : 1'b0;
                offers++;
                checks++;
                if (pend !== 1'b1 || int'(bus.assign_car) !== ec) begin
                    failures++;
                    $display("FAIL rand_offer@%0d: got fl=%0d up=%b pending=%b car=%0d expected pending=1 car=%0d",
                             cyc, f, bus.assign_up, pend, bus.assign_car, ec);
                end
                in_offer = 1'b1;
                o_car = bus.assign_car;
                o_fl  = bus.assign_floor;
                o_up  = bus.assign_up;
            end
            // Next cycle's stimulus.
            rdy = v ? ($urandom_range(0, 2) == 0) : 1'($urandom_range(0, 1));
            pv  = ($urandom_range(0, 2) == 0);
            pf  = $urandom_range(0, 7);
            pup = 1'($urandom_range(0, 1));
            bus.assign_ready   = rdy;
            bus.hall_req_valid = pv;
            bus.hall_req_floor = FW'(pf);
            bus.hall_req_up    = pup;
            bus.car_idle       = EC'($urandom_range(0, 3));
            for (int i = 0; i < EC; i++) bus.car_floor[i*FW +: FW] = FW'($urandom_range(0, FC - 1));
            // Model effect of the coming edge.
            hs = v && rdy;
            if (hs) begin
                if (o_up) m_up[o_fl] = 1'b0;
                else      m_dn[o_fl] = 1'b0;
                m_last   = int'(o_car);
                in_offer = 1'b0;
            end
            if (pv && press_legal(pf, pup) && !(hs && int'(o_fl) == pf && o_up == pup)) begin
                if (pup) m_up[pf] = 1'b1;
                else     m_dn[pf] = 1'b1;
            end
            last_hs   = hs;
            prev_idle = bus.car_idle;
            prev_fl   = bus.car_floor;
            @(negedge clk);
        end
        checks++;
        if (offers < 50) begin
            failures++;
            $display("FAIL rand_progress: got %0d offers expected at least 50", offers);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_ignored();
        test_no_idle();
        test_scan_order();
        test_clear_wins();
        test_reset_mid_offer();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
